// File: rtl/gol_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gol_sequencer
// Purpose  : Control sequencer for the Game-of-Life board engine. Converts
//            raw push-buttons and speed switches into single-cycle
//            load/run/reset strobes. Tracks the next row to load, paces
//            generations with a programmable tick and counts generations.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   btn_load   in   raw button, one press loads one row
//   btn_run    in   raw button, toggles run/pause
//   btn_step   in   raw button, one generation while paused
//   btn_clear  in   raw button, clears board and restarts loading
//   speed      in   [3:0] generation period = TICK_BASE*(speed+1) cycles
//   gen_limit  in   [GEN_W-1:0] auto-pause count, 0 = off
//                   (only with GOL_GEN_LIMIT_EN)
//   game_load  out  one-cycle row-load strobe
//   game_run   out  one-cycle generation strobe
//   game_reset out  board reset strobe
//   load_row   out  [$clog2(HEIGHT)-1:0] next row to be loaded
//   gen_count  out  [GEN_W-1:0] generations since last clear, saturating
//   state_out  out  [2:0] CLR=0 LOAD=1 IDLE=2 RUN=3 STEP=4
// Optional feature macro: GOL_GEN_LIMIT_EN (adds gen_limit auto-pause).
// ============================================================================
module gol_sequencer #(
  parameter int HEIGHT      = 20,
  parameter int TICK_BASE   = 1000000,
  parameter int SYNC_STAGES = 2,
  parameter int GEN_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      btn_load,
  input  logic                      btn_run,
  input  logic                      btn_step,
  input  logic                      btn_clear,
  input  logic [3:0]                speed,
`ifdef GOL_GEN_LIMIT_EN
  input  logic [GEN_W-1:0]          gen_limit,
`endif
  output logic                      game_load,
  output logic                      game_run,
  output logic                      game_reset,
  output logic [$clog2(HEIGHT)-1:0] load_row,
  output logic [GEN_W-1:0]          gen_count,
  output logic [2:0]                state_out
);

  localparam int ROW_W = $clog2(HEIGHT);
  // Prescaler must hold up to TICK_BASE*16-1 (speed=15).
  localparam int PS_W  = $clog2(TICK_BASE * 16 + 1);

  localparam logic [PS_W-1:0]  TICK_C    = PS_W'(TICK_BASE);
  localparam logic [ROW_W-1:0] FIRST_ROW = ROW_W'(1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(HEIGHT - 1);

  typedef enum logic [2:0] {
    ST_CLR  = 3'd0,
    ST_LOAD = 3'd1,
    ST_IDLE = 3'd2,
    ST_RUN  = 3'd3,
    ST_STEP = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Button synchronizers and rising-edge detectors.
  // Bit order of the button bus: {clear, run, step, load}.
  // --------------------------------------------------------------------------
  logic [3:0] btn_raw;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] prev_q;
  logic [3:0] btn_edge;

  assign btn_raw = {btn_clear, btn_run, btn_step, btn_load};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= btn_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign btn_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Priority clear > run > step > load: a higher edge masks all lower ones
  // in the same cycle, even when the higher edge is ignored by the state.
  logic clr_e, run_e, step_e, load_e;
  assign clr_e  = btn_edge[3];
  assign run_e  = btn_edge[2] & ~btn_edge[3];
  assign step_e = btn_edge[1] & ~(|btn_edge[3:2]);
  assign load_e = btn_edge[0] & ~(|btn_edge[3:1]);

  // --------------------------------------------------------------------------
  // Registered state and outputs
  // --------------------------------------------------------------------------
  state_t            state_q,      state_d;
  logic              game_load_q,  game_load_d;
  logic              game_run_q,   game_run_d;
  logic              game_reset_q, game_reset_d;
  logic [ROW_W-1:0]  load_row_q,   load_row_d;
  logic [GEN_W-1:0]  gen_count_q,  gen_count_d;
  logic [PS_W-1:0]   presc_q,      presc_d;

  // Tick limit for the current speed setting; compared with >= so that a
  // speed reduction below the current count fires on the next cycle.
  logic [PS_W-1:0] period;
  logic [PS_W-1:0] tick_max;
  logic            tick;

  assign period   = TICK_C * (PS_W'(speed) + PS_W'(1));
  assign tick_max = period - PS_W'(1);
  assign tick     = (presc_q >= tick_max);

  logic [GEN_W-1:0] gen_inc;
  assign gen_inc = (gen_count_q == '1) ? gen_count_q : gen_count_q + GEN_W'(1);

  logic [ROW_W-1:0] row_inc;
  assign row_inc = load_row_q + ROW_W'(1);

  logic limit_hit;
`ifdef GOL_GEN_LIMIT_EN
  assign limit_hit = (gen_limit != '0) && (gen_inc == gen_limit);
`else
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_CLR;
      game_load_q  <= 1'b0;
      game_run_q   <= 1'b0;
      game_reset_q <= 1'b1;
      load_row_q   <= FIRST_ROW;
      gen_count_q  <= '0;
      presc_q      <= '0;
    end else begin
      state_q      <= state_d;
      game_load_q  <= game_load_d;
      game_run_q   <= game_run_d;
      game_reset_q <= game_reset_d;
      load_row_q   <= load_row_d;
      gen_count_q  <= gen_count_d;
      presc_q      <= presc_d;
    end
  end

  // Strobes are computed for the state being entered, so game_run is seen
  // together with state_out=STEP and game_reset together with state_out=CLR.
  always_comb begin
    state_d      = state_q;
    game_load_d  = 1'b0;
    game_run_d   = 1'b0;
    game_reset_d = 1'b0;
    load_row_d   = load_row_q;
    gen_count_d  = gen_count_q;
    presc_d      = presc_q;

    if (clr_e) begin
      state_d      = ST_CLR;
      game_reset_d = 1'b1;
      load_row_d   = FIRST_ROW;
      gen_count_d  = '0;
      presc_d      = '0;
    end else begin
      case (state_q)
        ST_CLR: begin
          state_d     = ST_LOAD;
          load_row_d  = FIRST_ROW;
          gen_count_d = '0;
          presc_d     = '0;
        end

        ST_LOAD: begin
          if (run_e) begin
            state_d = ST_RUN;
            presc_d = '0;
          end else if (load_e) begin
            game_load_d = 1'b1;
            load_row_d  = row_inc;
            if (row_inc == LAST_ROW) begin
              state_d = ST_IDLE;
            end
          end
        end

        ST_IDLE: begin
          if (run_e) begin
            state_d = ST_RUN;
            presc_d = '0;
          end else if (step_e) begin
            state_d     = ST_STEP;
            game_run_d  = 1'b1;
            gen_count_d = gen_inc;
          end
        end

        ST_STEP: begin
          state_d = ST_IDLE;
        end

        ST_RUN: begin
          if (run_e) begin
            state_d = ST_IDLE;
            presc_d = '0;
          end else if (tick) begin
            // Prescaler restarts at 0 and tick_max >= 1, so game_run can
            // never fire on two consecutive cycles.
            presc_d     = '0;
            game_run_d  = 1'b1;
            gen_count_d = gen_inc;
            if (limit_hit) begin
              state_d = ST_IDLE;
            end
          end else begin
            presc_d = presc_q + PS_W'(1);
          end
        end

        default: begin
          state_d      = ST_CLR;
          game_reset_d = 1'b1;
          load_row_d   = FIRST_ROW;
          gen_count_d  = '0;
          presc_d      = '0;
        end
      endcase
    end
  end

  assign game_load  = game_load_q;
  assign game_run   = game_run_q;
  assign game_reset = game_reset_q;
  assign load_row   = load_row_q;
  assign gen_count  = gen_count_q;
  assign state_out  = state_q;

endmodule
`default_nettype wire

// File: doc/gol_sequencer.md
Name: gol_sequencer

Overview:
Control sequencer for the Game-of-Life board engine. It turns raw push-buttons and speed switches into the engine's single-cycle load/run/reset strobes. It tracks the row being loaded, paces generations with a programmable tick, and counts generations. It sits between the board I/O (buttons, switches) and the board engine.

Parameters:
HEIGHT, 20, board rows including the top and bottom zero rows; the loadable rows are 1..HEIGHT-2.
TICK_BASE, 1000000, clk cycles per generation at speed=0; must be >= 2.
SYNC_STAGES, 2, synchronizer flops per button input; must be >= 2.
GEN_W, 16, generation counter width.

Ports:
clk  in  1  system clock
reset  in  1  async active-high reset
btn_load  in  1  raw button; one press loads one row
btn_run  in  1  raw button; toggles run/pause
btn_step  in  1  raw button; advances one generation while paused
btn_clear  in  1  raw button; clears the board and restarts loading
speed  in  4  generation period = TICK_BASE*(speed+1) cycles
game_load  out  1  one-cycle row-load strobe to the engine
game_run  out  1  one-cycle generation strobe to the engine
game_reset  out  1  board reset strobe to the engine
load_row  out  $clog2(HEIGHT)  next row to be loaded
gen_count  out  GEN_W  generations since the last clear, saturating
state_out  out  3  CLR=0, LOAD=1, IDLE=2, RUN=3, STEP=4

Behaviour:
- Reset is asynchronous (no reset synchronizer on its assertion edge). While reset is high:
  - state=CLR, game_reset=1.
  - game_load=0, game_run=0, load_row=1, gen_count=0.
  - Prescaler=0 and the synchronizer/edge flops are 0.
- Button inputs:
  - Each btn_* passes through SYNC_STAGES flops, then a rising-edge detector.
  - The "edge" below is a one-cycle pulse. Edge latency is SYNC_STAGES+1 cycles from the raw rise.
- Edge priority when several occur in the same cycle: clear > run > step > load. Lower-priority edges in that cycle are dropped.
- CLR state:
  - Drives game_reset=1 for exactly one cycle.
  - Sets load_row=1, gen_count=0, prescaler=0.
  - Goes to LOAD.
- LOAD state:
  - Load edge: game_load=1 for one cycle, load_row+1.
  - If load_row becomes HEIGHT-1, go to IDLE.
  - Run edge: go to RUN; rows not yet loaded stay zero.
  - Step edge: ignored.
- IDLE state:
  - Run edge: go to RUN with prescaler=0.
  - Step edge: go to STEP.
  - Load edge: ignored.
- STEP state: game_run=1 for one cycle, gen_count+1, then IDLE.
- RUN state:
  - Prescaler counts every cycle.
  - When prescaler >= TICK_BASE*(speed+1)-1: prescaler=0, game_run=1 for one cycle, gen_count+1.
  - A speed change that leaves the prescaler at or above the new limit fires on the next cycle.
  - Run edge: go to IDLE with prescaler=0.
- Clear edge in any state: go to CLR.
- game_run is never asserted on two consecutive cycles; the engine commits its result on the cycle after the strobe.
- game_load and game_run are never high together.
- gen_count saturates at 2^GEN_W-1.
- All outputs are registered.

Optional Feature:
GOL_GEN_LIMIT_EN:
- When defined, adds input port gen_limit (GEN_W bits).
- In RUN, a tick that makes gen_count equal gen_limit still issues game_run, then auto-pauses to IDLE in the same transition.
- gen_limit=0 disables the limit.
- STEP is unaffected by the limit.
- When undefined, the port is absent and RUN continues until a run or clear edge.

Test Plan:
- Reset release -> one cycle of game_reset=1 (CLR), then state_out=1 (LOAD), load_row=1, gen_count=0.
- HEIGHT=20; 18 btn_load presses -> 18 single-cycle game_load pulses; load_row goes 1..19; state_out=2 (IDLE) after the 18th press; a 19th press gives no pulse.
- TICK_BASE=4, speed=1, btn_run press -> game_run pulses exactly every 8 cycles; gen_count=3 after 3 pulses; a second btn_run press -> IDLE with no further pulses.
- In IDLE, btn_step pressed twice -> exactly 2 game_run pulses, gen_count+2, state_out returns to 2 after each.
- Clear, run and step edges in the same cycle while in RUN -> CLR wins: one game_reset pulse, gen_count=0, load_row=1, state_out=1.
- GOL_GEN_LIMIT_EN defined, gen_limit=5, TICK_BASE=4, speed=0 -> 5 game_run pulses, then state_out=2 and gen_count holds at 5.
